// File: rtl/taptempo_pkg.sv
// Shared constants and types for the tap-tempo datapath.
//   TICK_NS            duration of one timepulse tick
//   DEF_MIN_TICKS      default shortest accepted tap interval (~120 ms)
//   DEF_TIMEOUT_TICKS  default interval at which a measurement is abandoned (~2 s)
//   HIST_DEPTH/SHIFT   moving-average depth and its log2
//   state_e            tap_period_ctrl FSM encoding
package taptempo_pkg;

  localparam int TICK_NS           = 5120;
  localparam int DEF_MIN_TICKS     = 23438;
  localparam int DEF_TIMEOUT_TICKS = 390625;
  localparam int HIST_DEPTH        = 4;
  localparam int HIST_SHIFT        = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/period_avg.sv
// Four-slot interval history with moving-average output stage.
//   clk_i, rstn_i    clock, asynchronous active-low reset
//   cap_valid_i      a new interval has been captured this cycle
//   cap_val_i        the captured interval in ticks
//   timeout_i        measurement abandoned: next capture reseeds the history
//   period_o         averaged interval (sum of slots >> HIST_SHIFT)
//   period_valid_o   period_o holds an unconsumed result
//   period_ready_i   consumer accepts period_o
module period_avg
  import taptempo_pkg::*;
#(
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   cap_valid_i,
  input  logic [COUNT_WIDTH-1:0] cap_val_i,
  input  logic                   timeout_i,
  output logic [COUNT_WIDTH-1:0] period_o,
  output logic                   period_valid_o,
  input  logic                   period_ready_i
);

  localparam int SUM_W = COUNT_WIDTH + HIST_SHIFT;

  logic [COUNT_WIDTH-1:0] slot_q [HIST_DEPTH];
  logic [COUNT_WIDTH-1:0] slot_d [HIST_DEPTH];
  logic                   first_q, first_d;
  logic                   pipe_q, pipe_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [SUM_W-1:0]       hist_sum;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   valid_q, valid_d;

  // History update: the first capture after reset or timeout fills every
  // slot so the average is not dragged toward zero or stale intervals.
  always_comb begin
    first_d = first_q;
    for (int i = 0; i < HIST_DEPTH; i++) slot_d[i] = slot_q[i];
    if (cap_valid_i) begin
      first_d = 1'b0;
      if (first_q) begin
        for (int i = 0; i < HIST_DEPTH; i++) slot_d[i] = cap_val_i;
      end else begin
        slot_d[0] = cap_val_i;
        for (int i = 1; i < HIST_DEPTH; i++) slot_d[i] = slot_q[i-1];
      end
    end else if (timeout_i) begin
      first_d = 1'b1;
    end
  end

  // The adder works on the post-update slots so the sum register is loaded
  // on the capture edge, keeping tap-to-valid latency at two cycles.
  always_comb begin
    hist_sum = '0;
    for (int i = 0; i < HIST_DEPTH; i++) hist_sum = hist_sum + SUM_W'(slot_d[i]);
  end

  always_comb begin
    sum_d    = cap_valid_i ? hist_sum : sum_q;
    pipe_d   = cap_valid_i;
    period_d = period_q;
    valid_d  = valid_q;
    // A fresh result overrides both a pending value and an acceptance.
    if (pipe_q) begin
      period_d = sum_q[SUM_W-1:HIST_SHIFT];
      valid_d  = 1'b1;
    end else if (valid_q && period_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < HIST_DEPTH; i++) slot_q[i] <= '0;
      first_q  <= 1'b1;
      pipe_q   <= 1'b0;
      sum_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < HIST_DEPTH; i++) slot_q[i] <= slot_d[i];
      first_q  <= first_d;
      pipe_q   <= pipe_d;
      sum_q    <= sum_d;
      period_q <= period_d;
      valid_q  <= valid_d;
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = valid_q;

endmodule

// File: rtl/tap_period_ctrl.sv
// Tap interval measurement: counts timepulse ticks between debounced taps,
// rejects taps closer than MIN_TICKS, abandons at TIMEOUT_TICKS, and feeds
// accepted intervals to the moving-average stage.
//   clk_i, rstn_i    clock, asynchronous active-low reset
//   tp_i             timepulse strobe (one cycle)
//   tap_i            debounced tap pulse (one cycle)
//   period_o         averaged interval in ticks, valid/ready handshake
//   period_valid_o   period_o valid
//   period_ready_i   consumer accepts period_o
//   timeout_o        one-cycle pulse when a measurement is abandoned
//   busy_o           high while measuring
module tap_period_ctrl
  import taptempo_pkg::*;
#(
  parameter int COUNT_WIDTH   = 20,
  parameter int MIN_TICKS     = DEF_MIN_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   tp_i,
  input  logic                   tap_i,
  output logic [COUNT_WIDTH-1:0] period_o,
  output logic                   period_valid_o,
  input  logic                   period_ready_i,
  output logic                   timeout_o,
  output logic                   busy_o
);

  // The timeout keeps the counter below TIMEOUT_TICKS, so it can never wrap
  // as long as the timeout itself fits in COUNT_WIDTH bits.
  if (TIMEOUT_TICKS <= MIN_TICKS ||
      longint'(TIMEOUT_TICKS) >= (longint'(1) << COUNT_WIDTH)) begin : g_param_check
    $error("tap_period_ctrl: need MIN_TICKS < TIMEOUT_TICKS < 2**COUNT_WIDTH");
  end

  localparam logic [COUNT_WIDTH-1:0] MIN_L     = COUNT_WIDTH'(MIN_TICKS);
  localparam logic [COUNT_WIDTH:0]   TIMEOUT_L = (COUNT_WIDTH+1)'(TIMEOUT_TICKS);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic [COUNT_WIDTH:0]   cnt_inc;
  logic                   cap_valid;
  logic [COUNT_WIDTH-1:0] cap_val;

  assign cnt_inc = {1'b0, cnt_q} + (COUNT_WIDTH+1)'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    cap_valid = 1'b0;
    // A tick landing on the tap cycle belongs to the interval being closed.
    cap_val   = cnt_q + COUNT_WIDTH'(tp_i);
    case (state_q)
      ST_IDLE: begin
        if (tap_i) begin
          cnt_d   = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // An accepted tap takes priority over a coincident timeout tick.
        if (tap_i && cnt_q >= MIN_L) begin
          cap_valid = 1'b1;
          cnt_d     = '0;
        end else if (tp_i) begin
          if (cnt_inc < TIMEOUT_L) begin
            cnt_d = cnt_inc[COUNT_WIDTH-1:0];
          end else begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  period_avg #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_avg (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .cap_valid_i    (cap_valid),
    .cap_val_i      (cap_val),
    .timeout_i      (timeout_d),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .period_ready_i (period_ready_i)
  );

  assign timeout_o = timeout_q;
  assign busy_o    = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_tap_period_ctrl.sv
module tb_tap_period_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn_i = 1'b1;
  logic         tp_i = 1'b0;
  logic         tap_i = 1'b0;
  logic         period_ready_i = 1'b1;
  logic [W-1:0] period_o;
  logic         period_valid_o;
  logic         timeout_o;
  logic         busy_o;

  int n_checks = 0;
  int n_fails  = 0;
  int to_cnt   = 0;

  tap_period_ctrl #(
    .COUNT_WIDTH  (W),
    .MIN_TICKS    (10),
    .TIMEOUT_TICKS(100)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .tp_i           (tp_i),
    .tap_i          (tap_i),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .period_ready_i (period_ready_i),
    .timeout_o      (timeout_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  // Counts timeout pulses seen on the inactive edge.
  always @(negedge clk) if (timeout_o === 1'b1) to_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; every task returns at a falling edge.
  task automatic step(input logic tp, input logic tap);
    tp_i  = tp;
    tap_i = tap;
    @(posedge clk);
    @(negedge clk);
    tp_i  = 1'b0;
    tap_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // One tick every fourth cycle.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      idle(3);
      step(1'b1, 1'b0);
    end
  endtask

  task automatic tap();
    step(1'b0, 1'b1);
  endtask

  // Close an interval of n ticks and check the result lands two cycles
  // after the tap and is consumed one cycle later (ready held high).
  task automatic interval(input string tag, input int n, input int exp);
    ticks(n);
    tap();
    check({tag, "_valid_n1"}, period_valid_o, 0);
    idle(1);
    check({tag, "_valid_n2"}, period_valid_o, 1);
    check({tag, "_period"}, period_o, exp);
    idle(1);
    check({tag, "_valid_drop"}, period_valid_o, 0);
  endtask

  initial begin
    // Reset
    #1 rstn_i = 1'b0;
    @(negedge clk);
    idle(2);
    check("rst_period", period_o, 0);
    check("rst_valid", period_valid_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_busy", busy_o, 0);
    rstn_i = 1'b1;
    idle(2);

    // 1: first interval seeds the history
    tap();
    check("t1_busy", busy_o, 1);
    interval("t1", 40, 40);
    interval("t2a", 40, 40);
    interval("t2b", 40, 40);

    // 3: early tap ignored, interval still measured from the original tap
    ticks(5);
    tap();
    check("t3_busy", busy_o, 1);
    idle(1);
    check("t3_no_result", period_valid_o, 0);
    ticks(35);
    tap();
    idle(1);
    check("t3_valid", period_valid_o, 1);
    check("t3_period", period_o, 40);
    idle(1);

    // 2 (cont.): longer interval averaged in: (80+40+40+40)/4
    interval("t2c", 80, 50);
    check("t1_no_timeout", to_cnt, 0);

    // 4: timeout at tick 100, then reseed with a short pair
    ticks(99);
    check("t4_busy_before", busy_o, 1);
    check("t4_no_early_to", timeout_o, 0);
    idle(3);
    step(1'b1, 1'b0);
    check("t4_timeout", timeout_o, 1);
    check("t4_busy_after", busy_o, 0);
    idle(1);
    check("t4_timeout_drop", timeout_o, 0);
    idle(2);
    check("t4_single_pulse", to_cnt, 1);
    tap();
    interval("t4", 20, 20);

    // 5: reseed to 40 via another timeout, then backpressure
    ticks(100);
    idle(2);
    check("t5_timeout_cnt", to_cnt, 2);
    check("t5_idle", busy_o, 0);
    tap();
    period_ready_i = 1'b0;
    ticks(40);
    tap();
    idle(1);
    check("t5_valid1", period_valid_o, 1);
    check("t5_period1", period_o, 40);
    ticks(60);
    check("t5_hold_valid", period_valid_o, 1);
    check("t5_hold_period", period_o, 40);
    tap();
    idle(1);
    check("t5_valid2", period_valid_o, 1);
    check("t5_period2", period_o, 45);
    idle(5);
    check("t5_stable_valid", period_valid_o, 1);
    check("t5_stable_period", period_o, 45);
    period_ready_i = 1'b1;
    idle(1);
    check("t5_drop", period_valid_o, 0);

    // 6: asynchronous reset while measuring with a result pending
    period_ready_i = 1'b0;
    ticks(40);
    tap();
    idle(1);
    check("t6_pending", period_valid_o, 1);
    check("t6_pending_period", period_o, 45);
    check("t6_busy", busy_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    check("t6_rst_period", period_o, 0);
    check("t6_rst_valid", period_valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_timeout", timeout_o, 0);
    @(negedge clk);
    idle(2);
    rstn_i = 1'b1;
    period_ready_i = 1'b1;
    idle(2);
    tap();
    check("t6_start_busy", busy_o, 1);
    idle(2);
    check("t6_start_no_out", period_valid_o, 0);
    interval("t6", 30, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
